// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM encoding and default width for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The shifted remainder keeps its top bit so divisors above 2^(WIDTH-1) still divide correctly.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   sel;
    logic             unused_sel_hi;

    assign shifted        = {rem_i, msb_i};
    assign {borrow, diff} = {1'b0, shifted} - {2'b00, divisor_i};
    assign sel            = borrow ? shifted : diff;
    assign rem_o          = sel[WIDTH-1:0];
    assign unused_sel_hi  = sel[WIDTH];
    assign q_bit_o        = ~borrow;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider; SIGNED_DIV_EN adds two's-complement mode
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
`ifdef SIGNED_DIV_EN
    input  logic             i_signed,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] rem_out_q;

    logic             signed_op;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] rem_d;
    logic             q_bit;
    logic [WIDTH-1:0] quo_d;

`ifdef SIGNED_DIV_EN
    assign signed_op = i_signed;
`else
    assign signed_op = 1'b0;
`endif

    assign dvd_neg = signed_op & i_dividend[WIDTH-1];
    assign dvs_neg = signed_op & i_divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -i_dividend : i_dividend;
    assign dvs_mag = dvs_neg ? -i_divisor  : i_divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .msb_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit)
    );

    // Quotient bits shift into the vacated low end of the dividend register.
    assign quo_d = {dvd_q[WIDTH-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (i_start) begin
                        if (i_divisor == '0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            dz_q      <= 1'b1;
                            quo_out_q <= '1;
                            rem_out_q <= i_dividend;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            dvd_q   <= dvd_mag;
                            dvs_q   <= dvs_mag;
                            rem_q   <= '0;
                            cnt_q   <= CW'(WIDTH - 1);
                            q_neg_q <= dvd_neg ^ dvs_neg;
                            r_neg_q <= dvd_neg;
                        end
                    end
                end
                RUN: begin
                    dvd_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        dz_q      <= 1'b0;
                        quo_out_q <= q_neg_q ? -quo_d : quo_d;
                        rem_out_q <= r_neg_q ? -rem_d : rem_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_quotient  = quo_out_q;
    assign o_remainder = rem_out_q;
    assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider; SIGNED_DIV_EN enables signed cases
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
`ifdef SIGNED_DIV_EN
    logic         i_signed = 1'b0;
`endif
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
`ifdef SIGNED_DIV_EN
        .i_signed    (i_signed),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           start;
    } exp_t;

    exp_t sb[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_run = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sd;
        e.start = 0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            e.q = W'(sa / sd); e.r = W'(sa % sd); e.dz = 1'b0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse; latency is counted in edges after the accepting edge.
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_overlap", W'(o_busy & o_done), '0);
        if (!reset_n) busy_run = 0;
        else if (o_busy) busy_run++;
        if (o_done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_done: got done with no operation pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", o_quotient, e.q);
                check("remainder", o_remainder, e.r);
                check("div_zero", W'(o_div_zero), W'(e.dz));
                check("latency", W'(cyc - e.start), e.dz ? '0 : W'(W));
                check("busy_cycles", W'(busy_run), e.dz ? '0 : W'(W));
            end
            busy_run = 0;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        exp_t e;
        i_start = 1'b1;
        i_dividend = a;
        i_divisor = b;
`ifdef SIGNED_DIV_EN
        i_signed = s;
`endif
        @(posedge clk);
        #1;
        if (push) begin
            e = model(a, b, s);
            e.start = cyc;
            sb.push_back(e);
        end
        i_start = 1'b0;
        i_dividend = $urandom;
        i_divisor = $urandom;
    endtask

    task automatic wait_done();
        for (int k = 0; k < W + 10; k++) begin
            @(negedge clk);
            if (o_done) return;
        end
        total_cnt++;
        $display("FAIL done_timeout: got no done within %0d cycles expected one", W + 10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;

        repeat (3) @(negedge clk);
        check("reset_busy", W'(o_busy), '0);
        check("reset_done", W'(o_done), '0);
        check("reset_quotient", o_quotient, '0);
        check("reset_remainder", o_remainder, '0);
        check("reset_div_zero", W'(o_div_zero), '0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(32'd5, 32'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        // Start during RUN is ignored; a start in the DONE cycle runs back-to-back.
        issue(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        i_start = 1'b1; i_dividend = 32'd9; i_divisor = 32'd3;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        issue(32'd9, 32'd3, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        wait_done();
        issue(32'd3, 32'd10, 1'b0, 1'b1);
        wait_done();
        issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

`ifdef SIGNED_DIV_EN
        issue(-32'sd7, 32'd2, 1'b1, 1'b1);
        wait_done();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done();
        issue(-32'sd9, 32'd0, 1'b1, 1'b1);
        wait_done();
        @(negedge clk);
`endif

        // Reset mid-RUN aborts with no done.
        issue(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(o_busy), '0);
        check("abort_done", W'(o_done), '0);
        check("abort_quotient", o_quotient, '0);
        check("abort_remainder", o_remainder, '0);
        reset_n = 1'b1;
        repeat (2 * W) @(negedge clk);
        issue(32'd1000, 32'd33, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3, 4:    b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
`ifdef SIGNED_DIV_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            issue(a, b, s, 1'b1);
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
